mul_seq_ctrl: RTL and testbench

//  Execute-stage sequencer around the combinational 32x32 multiplier (mul32).

---
 rtl/mul_seq_ctrl_if.sv | 21 ++
 rtl/mul_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand/result bundle between the execute pipeline and mul_seq_ctrl.
interface mul_seq_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        overflow;

    modport master (
        output start, signed_op, inA, inB,
        input  busy, done, out, overflow
    );

    modport slave (
        input  start, signed_op, inA, inB,
        output busy, done, out, overflow
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Execute-stage sequencer around a combinational 32x32 multiplier with a multicycle settle window.
// Optional feature macro: MUL_ZERO_BYPASS_EN (skips the settle window when either magnitude is zero).
module mul_seq_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    mul_seq_ctrl_if.slave bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   op_a, op_a_nxt;
    logic [DATA_W-1:0]   op_b, op_b_nxt;
    logic                neg, neg_nxt;
    logic                sgn, sgn_nxt;
    logic [DATA_W-1:0]   out_q, out_nxt;
    logic                ovf_q, ovf_nxt;
    logic                done_q, done_nxt;
    logic                busy_q, busy_nxt;

    logic [DATA_W-1:0]   mag_a_c, mag_b_c;
    logic [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]   p_c;
    logic                mul_ovf_c;

    // Operand magnitudes; INT_MIN maps to itself, which mul32 treats as unsigned 2^31.
    assign mag_a_c = (bus.signed_op & bus.inA[31]) ? DATA_W'(-bus.inA) : bus.inA;
    assign mag_b_c = (bus.signed_op & bus.inB[31]) ? DATA_W'(-bus.inB) : bus.inB;

    // mul32: combinational unsigned product, allowed WAIT_CYCLES edges to settle.
    assign prod_c    = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    assign p_c       = prod_c[DATA_W-1:0];
    assign mul_ovf_c = |prod_c[2*DATA_W-1:DATA_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            count  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            neg    <= 1'b0;
            sgn    <= 1'b0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            op_a   <= op_a_nxt;
            op_b   <= op_b_nxt;
            neg    <= neg_nxt;
            sgn    <= sgn_nxt;
            out_q  <= out_nxt;
            ovf_q  <= ovf_nxt;
            done_q <= done_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        op_a_nxt  = op_a;
        op_b_nxt  = op_b;
        neg_nxt   = neg;
        sgn_nxt   = sgn;
        out_nxt   = out_q;
        ovf_nxt   = ovf_q;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_nxt  = mag_a_c;
                    op_b_nxt  = mag_b_c;
                    neg_nxt   = bus.signed_op & (bus.inA[31] ^ bus.inB[31]);
                    sgn_nxt   = bus.signed_op;
                    count_nxt = CNT_W'(WAIT_CYCLES);
`ifdef MUL_ZERO_BYPASS_EN
                    if ((mag_a_c == '0) || (mag_b_c == '0)) begin
                        state_nxt = S_RESULT;
                    end else begin
                        state_nxt = S_WAIT;
                    end
`else
                    state_nxt = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                out_nxt   = neg ? DATA_W'(-p_c) : p_c;
                // Signed: magnitude must fit 31 bits, except exactly 2^31 for a negative result.
                ovf_nxt   = sgn ? (mul_ovf_c | (p_c[31] & ~(neg & (p_c == INT_MIN))))
                                : mul_ovf_c;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table plus multi-cycle corner sequences.
module tb_mul_seq_ctrl;

    localparam int unsigned WAIT_CYCLES = 2;
    localparam int          FULL_LAT    = WAIT_CYCLES + 2;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int          ZERO_LAT    = 2;
`else
    localparam int          ZERO_LAT    = FULL_LAT;
`endif

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    mul_seq_ctrl_if bus();

    mul_seq_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one operation, then count cycles (sampled at negedge) until done; busy must be high until then.
    task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.signed_op = sop;
        bus.inA       = a;
        bus.inB       = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (bus.done) begin
                if (bus.busy) busy_ok = 1'b0;
                break;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("wait_idle_timeout", 64'(n < 20), 64'd1);
    endtask

    int   lat;
    logic busy_ok;
    int   exp_lat;
    int   cyc;
    int   first_done;
    int   second_done;
    logic saw_done;

    initial begin
        checks = 0;
        errors = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.inA       = '0;
        bus.inB       = '0;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd42,         1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b1};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[5] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b1};
        vecs[6] = '{1'b0, 32'h0000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0};
        vecs[7] = '{1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFB,  32'd15,         1'b0};
        vecs[8] = '{1'b1, 32'h0001_0000,  32'h0000_8000,  32'h8000_0000,  1'b1};
        vecs[9] = '{1'b1, 32'hFFFF_0000,  32'h0000_8000,  32'h8000_0000,  1'b0};

        #12;
        check("reset_outputs", {28'd0, bus.busy, bus.done, bus.overflow, 1'b0, bus.out},
              64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sop, vecs[i].a, vecs[i].b, lat, busy_ok);
            exp_lat = ((vecs[i].a == 0) || (vecs[i].b == 0)) ? ZERO_LAT : FULL_LAT;
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
            check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_out", i), 64'(bus.out), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
        end

        // done is a single-cycle pulse and results hold afterwards
        @(negedge clock);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("out_hold", 64'(bus.out), 64'h8000_0000);

        // Start pulse during WAIT with different operands is ignored
        @(negedge clock);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.inA = 32'd7; bus.inB = 32'd6;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.signed_op = 1'b1; bus.inA = 32'd100; bus.inB = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 2;
        while (!bus.done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("ignored_start_latency", 64'(lat), 64'(FULL_LAT));
        check("ignored_start_out", 64'(bus.out), 64'd42);
        check("ignored_start_ovf", 64'(bus.overflow), 64'd0);
        @(negedge clock);
        check("ignored_start_no_extra_op", 64'(bus.busy), 64'd0);

        // start held high: back-to-back results every WAIT_CYCLES+2 cycles
        @(negedge clock);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.inA = 32'd3; bus.inB = 32'd4;
        first_done = -1; second_done = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (bus.done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        bus.start = 1'b0;
        check("b2b_first_latency", 64'(first_done), 64'(FULL_LAT));
        check("b2b_period", 64'(second_done - first_done), 64'(WAIT_CYCLES + 2));
        check("b2b_out", 64'(bus.out), 64'd12);
        wait_idle();

        // Reset mid-operation clears everything immediately and suppresses done
        @(negedge clock);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.inA = 32'hFFFF_FFFF; bus.inB = 32'd2;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        check("pre_reset_out_nonzero", 64'(bus.out != 0), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {28'd0, bus.busy, bus.done, bus.overflow, 1'b0, bus.out},
              64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);

        run_op(1'b0, 32'd2, 32'd3, lat, busy_ok);
        check("post_reset_latency", 64'(lat), 64'(FULL_LAT));
        check("post_reset_out", 64'(bus.out), 64'd6);
        check("post_reset_ovf", 64'(bus.overflow), 64'd0);

        // Zero operand in signed mode still obeys the bypass/full latency rule
        run_op(1'b1, 32'hFFFF_FFFF, 32'd0, lat, busy_ok);
        check("zero_signed_latency", 64'(lat), 64'(ZERO_LAT));
        check("zero_signed_out", 64'(bus.out), 64'd0);
        check("zero_signed_busy", 64'(busy_ok), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
